// File: rtl/btn_debounce_toggle.sv
// -----------------------------------------------------------------------------
// btn_debounce_toggle
//   Conditions a raw mechanical switch/button pin for downstream control FSMs.
//   The pin is synchronised by a 2-FF chain and then sampled on a slow tick.
//   A new level is committed only after STABLE_TICKS consecutive ticks agree.
//   On commit the block registers a clean level and a one-clock edge pulse.
//   A toggle flag flips on every rising commit.
//
// Parameters
//   TICK_DIV      clocks per sample tick (>= 2)
//   STABLE_TICKS  consecutive agreeing ticks needed to commit a level (>= 1)
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous, active-high; clears every register
//   btn_in      in   raw asynchronous switch/button pin
//   level       out  debounced, registered input level
//   rise_pulse  out  one-clock pulse when level commits 0->1
//   fall_pulse  out  one-clock pulse when level commits 1->0
//   toggle      out  flips on every rise_pulse (press-to-run flag)
// -----------------------------------------------------------------------------
module btn_debounce_toggle #(
    parameter int TICK_DIV     = 100_000,
    parameter int STABLE_TICKS = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    // The commit happens on the tick where cnt+1 reaches STABLE_TICKS.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; only s is used downstream.
    // ------------------------------------------------------------------
    logic sync_meta;
    logic s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            s         <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running sample-tick divider.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Qualification FSM: state register
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             commit_rise;
    logic             commit_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Qualification FSM: next-state logic (acts only on tick cycles)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        commit_rise = 1'b0;
        commit_fall = 1'b0;

        if (tick) begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_next  = IDLE_HIGH;
                            cnt_next    = '0;
                            commit_rise = 1'b1;
                        end else begin
                            state_next = WAIT_HIGH;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (!s) begin
                        // Bounce: restart qualification, outputs untouched.
                        state_next = IDLE_LOW;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next  = IDLE_HIGH;
                        cnt_next    = '0;
                        commit_rise = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                IDLE_HIGH: begin
                    if (!s) begin
                        if (STABLE_TICKS == 1) begin
                            state_next  = IDLE_LOW;
                            cnt_next    = '0;
                            commit_fall = 1'b1;
                        end else begin
                            state_next = WAIT_LOW;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end

                WAIT_LOW: begin
                    if (s) begin
                        state_next = IDLE_HIGH;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next  = IDLE_LOW;
                        cnt_next    = '0;
                        commit_fall = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                default: begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Qualification FSM: output logic. The outputs themselves are
    // registered below so level never has a combinational path from pins.
    // ------------------------------------------------------------------
    logic level_next;
    logic rise_next;
    logic fall_next;
    logic toggle_next;

    always_comb begin
        level_next  = level;
        rise_next   = commit_rise;
        fall_next   = commit_fall;
        toggle_next = toggle;

        if (commit_rise) begin
            level_next  = 1'b1;
            toggle_next = ~toggle;
        end else if (commit_fall) begin
            level_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            toggle     <= 1'b0;
        end else begin
            level      <= level_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            toggle     <= toggle_next;
        end
    end

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_toggle
//   Directed bench for btn_debounce_toggle with TICK_DIV=4, STABLE_TICKS=3.
//   Inputs change and outputs are sampled on the falling clock edge.
//   With the divider cleared by reset and the pin already high at release,
//   the level commits on the 12th rising edge after release: two synchroniser
//   clocks, the first tick on edge 4, then ticks on edges 8 and 12.
// -----------------------------------------------------------------------------
module tb_btn_debounce_toggle;

    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int MAX_LAT      = 15;

    logic clk;
    logic reset;
    logic btn_in;
    logic level;
    logic rise_pulse;
    logic fall_pulse;
    logic toggle;

    int n_checks;
    int n_fail;

    // Results of the most recent observe() window.
    int obs_rise;
    int obs_fall;
    int obs_level_at;

    btn_debounce_toggle #(
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .toggle     (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run n falling edges. Count cycles with each pulse high, and record the
    // first cycle (1-based) where level differs from its value at the start.
    task automatic observe(input int n);
        logic start_level;
        start_level  = level;
        obs_rise     = 0;
        obs_fall     = 0;
        obs_level_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (rise_pulse === 1'b1) obs_rise++;
            if (fall_pulse === 1'b1) obs_fall++;
            if (obs_level_at == 0 && level !== start_level) obs_level_at = i;
        end
    endtask

    // Hold reset for n clocks with the pin at btn, then release on a falling edge.
    task automatic apply_reset(input logic btn, input int n);
        reset  = 1'b1;
        btn_in = btn;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // 1: outputs held at zero under reset with the pin high, then a rise.
    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise_pulse, fall_pulse, toggle} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b%b%b%b expected 0000",
                         i, level, rise_pulse, fall_pulse, toggle);
            end
        end
        reset = 1'b0;
        observe(MAX_LAT);
        n_checks++;
        if (obs_level_at < 1 || obs_level_at > MAX_LAT) begin
            n_fail++;
            $display("FAIL reset_release_latency: got %0d expected 1..%0d", obs_level_at, MAX_LAT);
        end
        n_checks++;
        if (obs_rise != 1) begin
            n_fail++;
            $display("FAIL reset_release_rise_count: got %0d expected 1", obs_rise);
        end
        n_checks++;
        if (toggle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_toggle: got %b expected 1", toggle);
        end
    endtask

    // 2: clean press held 40 clocks.
    task automatic test_press();
        apply_reset(1'b0, 2);
        btn_in = 1'b1;
        observe(40);
        n_checks++;
        if (obs_level_at < 1 || obs_level_at > MAX_LAT) begin
            n_fail++;
            $display("FAIL press_latency: got %0d expected 1..%0d", obs_level_at, MAX_LAT);
        end
        n_checks++;
        if (obs_rise != 1) begin
            n_fail++;
            $display("FAIL press_rise_width: got %0d cycles expected 1", obs_rise);
        end
        n_checks++;
        if (obs_fall != 0) begin
            n_fail++;
            $display("FAIL press_fall_count: got %0d expected 0", obs_fall);
        end
        n_checks++;
        if (level !== 1'b1 || toggle !== 1'b1) begin
            n_fail++;
            $display("FAIL press_level_toggle: got level=%b toggle=%b expected 1 1", level, toggle);
        end
    endtask

    // 3: a 6-clock glitch spans at most two ticks and must be rejected.
    task automatic test_glitch();
        int rises;
        int falls;
        int moved;
        apply_reset(1'b0, 2);
        btn_in = 1'b1;
        observe(6);
        rises = obs_rise;
        falls = obs_fall;
        moved = obs_level_at;
        btn_in = 1'b0;
        observe(40);
        rises += obs_rise;
        falls += obs_fall;
        moved += obs_level_at;
        n_checks++;
        if (rises != 0 || falls != 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got rise=%0d fall=%0d expected 0 0", rises, falls);
        end
        n_checks++;
        if (moved != 0 || level !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_level: got moved_at=%0d level=%b expected 0 0", moved, level);
        end
        n_checks++;
        if (toggle !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_toggle: got %b expected 0", toggle);
        end
    endtask

    // 4: release then press again; toggle ignores the fall.
    task automatic test_release_press();
        apply_reset(1'b0, 2);
        btn_in = 1'b1;
        observe(40);
        n_checks++;
        if (level !== 1'b1 || toggle !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_setup: got level=%b toggle=%b expected 1 1", level, toggle);
        end
        btn_in = 1'b0;
        observe(40);
        n_checks++;
        if (obs_fall != 1 || obs_rise != 0) begin
            n_fail++;
            $display("FAIL rp_release_pulses: got fall=%0d rise=%0d expected 1 0", obs_fall, obs_rise);
        end
        n_checks++;
        if (obs_level_at < 1 || obs_level_at > MAX_LAT || level !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_release_level: got at=%0d level=%b expected 1..%0d 0",
                     obs_level_at, level, MAX_LAT);
        end
        n_checks++;
        if (toggle !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_release_toggle: got %b expected 1", toggle);
        end
        btn_in = 1'b1;
        observe(40);
        n_checks++;
        if (obs_rise != 1 || obs_fall != 0) begin
            n_fail++;
            $display("FAIL rp_press_pulses: got rise=%0d fall=%0d expected 1 0", obs_rise, obs_fall);
        end
        n_checks++;
        if (level !== 1'b1 || toggle !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_press_level_toggle: got level=%b toggle=%b expected 1 0", level, toggle);
        end
    endtask

    // 5: bounce 1,0,1,0 every 3 clocks, then hold 1.
    task automatic test_bounce();
        int rises;
        int falls;
        apply_reset(1'b0, 2);
        rises = 0;
        falls = 0;
        for (int k = 0; k < 4; k++) begin
            btn_in = (k % 2 == 0) ? 1'b1 : 1'b0;
            observe(3);
            rises += obs_rise;
            falls += obs_fall;
        end
        btn_in = 1'b1;
        observe(MAX_LAT);
        rises += obs_rise;
        falls += obs_fall;
        n_checks++;
        if (level !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_level_by_deadline: got %b expected 1", level);
        end
        observe(25);
        rises += obs_rise;
        falls += obs_fall;
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d expected 1", rises);
        end
        n_checks++;
        if (falls != 0 || level !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_final: got fall=%0d level=%b expected 0 1", falls, level);
        end
    endtask

    // 6: reset while qualifying a press (after the second tick, cnt=2).
    task automatic test_reset_mid_wait();
        apply_reset(1'b0, 2);
        btn_in = 1'b1;
        observe(9);
        n_checks++;
        if (obs_rise != 0 || level !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_early_commit: got rise=%0d level=%b expected 0 0", obs_rise, level);
        end
        reset = 1'b1;
        observe(1);
        n_checks++;
        if ({level, rise_pulse, fall_pulse, toggle} !== 4'b0000 || obs_rise != 0) begin
            n_fail++;
            $display("FAIL midwait_reset_outputs: got %b%b%b%b expected 0000",
                     level, rise_pulse, fall_pulse, toggle);
        end
        reset = 1'b0;
        observe(20);
        // Re-qualification from scratch commits on edge 12 after release.
        n_checks++;
        if (obs_level_at != 12) begin
            n_fail++;
            $display("FAIL midwait_requalify_latency: got %0d expected 12", obs_level_at);
        end
        n_checks++;
        if (obs_rise != 1 || toggle !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_requalify_rise: got rise=%0d toggle=%b expected 1 1", obs_rise, toggle);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        btn_in   = 1'b0;

        test_reset();
        test_press();
        test_glitch();
        test_release_press();
        test_bounce();
        test_reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
